// File: rtl/mem_arbiter_if.sv
// Bundle of requester, result and RAM command signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  // fetch requester
  logic        f_req;
  logic [7:0]  f_addr;
  // data requester
  logic        d_req;
  logic [7:0]  d_addr;
  logic        d_rw;
  logic [1:0]  d_type;
  logic [31:0] d_wdata;
  // completion
  logic        f_done;
  logic        d_done;
  logic        f_err;
  logic        d_err;
  logic [31:0] rdata;
  logic        busy;
  // RAM side
  logic        mem_mfa;
  logic [7:0]  mem_addr;
  logic        mem_rw;
  logic [1:0]  mem_type;
  logic [31:0] mem_wdata;
  logic        mem_mfc;
  logic [31:0] mem_dout;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_rw, d_type, d_wdata, mem_mfc, mem_dout,
    output f_done, d_done, f_err, d_err, rdata, busy,
    output mem_mfa, mem_addr, mem_rw, mem_type, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_rw, d_type, d_wdata, mem_mfc, mem_dout,
    input  f_done, d_done, f_err, d_err, rdata, busy,
    input  mem_mfa, mem_addr, mem_rw, mem_type, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter in front of a single RAM port,
// with an mfa/mfc handshake, access timeout and per-requester done/err pulses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;   // 1 = data requester owns the current access
  logic        last_q, last_d;     // 1 = data was granted last
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pick_data;

  // Data wins when alone, or on a tie when fetch was served last.
  assign pick_data = bus.d_req & (~bus.f_req | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.f_req || bus.d_req) begin
          grant_d = pick_data;
          last_d  = pick_data;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = StAccess;
          if (pick_data) begin
            addr_d  = bus.d_addr;
            rw_d    = bus.d_rw;
            type_d  = bus.d_type;
            wdata_d = bus.d_wdata;
          end else begin
            addr_d  = bus.f_addr;
            rw_d    = 1'b1;
            type_d  = 2'b10;
            wdata_d = 32'd0;
          end
        end
      end
      StAccess: begin
        // mfc takes priority over a timeout landing in the same cycle
        if (bus.mem_mfc) begin
          if (rw_q) begin
            rdata_d = bus.mem_dout;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CntLast) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      addr_q  <= 8'd0;
      rw_q    <= 1'b1;
      type_q  <= 2'b00;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign bus.mem_mfa   = (state_q == StAccess);
  assign bus.busy      = (state_q != StIdle);
  assign bus.f_done    = (state_q == StDone) & ~grant_q & ~err_q;
  assign bus.d_done    = (state_q == StDone) &  grant_q & ~err_q;
  assign bus.f_err     = (state_q == StDone) & ~grant_q &  err_q;
  assign bus.d_err     = (state_q == StDone) &  grant_q &  err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_type  = type_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table with a completion
// scoreboard, plus tie, reset-state and reset-mid-access sequences.
module tb_mem_arbiter;

  localparam int Timeout = 15;

  logic clk;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [7:0]  addr;
    logic        rw;
    logic [1:0]  typ;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          k;        // cycles after mfa rise that mfc is raised; -1 = never
    logic [7:0]  e_addr;
    logic        e_rw;
    logic [1:0]  e_type;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    bit          e_err;
    int          e_lat;    // cycles from mfa rise to the done/err pulse
  } vec_t;

  typedef struct {
    bit          is_data;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_mfa(output bit seen, output int idle_cycles);
    seen = 1'b0;
    idle_cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_mfa) seen = 1'b1;
      else if (!bus.busy) idle_cycles++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit   seen;
    bit   got;
    int   idle;
    int   t;
    exp_t e;
    bus.mem_dout  = v.dout;
    bus.f_addr    = v.addr;
    bus.d_addr    = v.addr;
    bus.d_rw      = v.rw;
    bus.d_type    = v.typ;
    bus.d_wdata   = v.wdata;
    bus.f_req     = !v.is_data;
    bus.d_req     = v.is_data;
    sb.push_back('{v.is_data, v.e_err, v.e_rdata, v.e_lat});
    wait_mfa(seen, idle);
    check($sformatf("v%0d_mfa_seen", idx), 32'(seen), 32'd1);
    check($sformatf("v%0d_mem_addr", idx), 32'(bus.mem_addr), 32'(v.e_addr));
    check($sformatf("v%0d_mem_rw", idx), 32'(bus.mem_rw), 32'(v.e_rw));
    check($sformatf("v%0d_mem_type", idx), 32'(bus.mem_type), 32'(v.e_type));
    check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.e_wdata);
    got = 1'b0;
    t = 0;
    while (!got && t < 60) begin
      if (t == v.k) bus.mem_mfc = 1'b1;
      @(negedge clk);
      t++;
      if (bus.f_done || bus.d_done || bus.f_err || bus.d_err) got = 1'b1;
    end
    check($sformatf("v%0d_completion_seen", idx), 32'(got), 32'd1);
    e = sb.pop_front();
    check($sformatf("v%0d_latency", idx), 32'(t), 32'(e.lat));
    check($sformatf("v%0d_f_done", idx), 32'(bus.f_done), 32'(!e.is_data && !e.err));
    check($sformatf("v%0d_d_done", idx), 32'(bus.d_done), 32'(e.is_data && !e.err));
    check($sformatf("v%0d_f_err", idx), 32'(bus.f_err), 32'(!e.is_data && e.err));
    check($sformatf("v%0d_d_err", idx), 32'(bus.d_err), 32'(e.is_data && e.err));
    check($sformatf("v%0d_rdata", idx), bus.rdata, e.rdata);
    check($sformatf("v%0d_mfa_low_in_done", idx), 32'(bus.mem_mfa), 32'd0);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    // mfc stays high into IDLE and must be ignored there
    @(negedge clk);
    check($sformatf("v%0d_busy_after", idx), 32'(bus.busy), 32'd0);
    check($sformatf("v%0d_pulse_once", idx),
          32'({bus.f_done, bus.d_done, bus.f_err, bus.d_err}), 32'd0);
    bus.mem_mfc = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_stay_idle", idx), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit   seen;
    bit   got;
    int   idle;
    bit   order[$];
    bit   want_data;

    bus.f_req    = 1'b0;
    bus.f_addr   = 8'd0;
    bus.d_req    = 1'b0;
    bus.d_addr   = 8'd0;
    bus.d_rw     = 1'b1;
    bus.d_type   = 2'b00;
    bus.d_wdata  = 32'd0;
    bus.mem_mfc  = 1'b0;
    bus.mem_dout = 32'd0;

    //              data addr   rw    typ    wdata         dout          k
    //              e_addr e_rw e_type e_wdata  e_rdata  e_err e_lat
    vecs[0] = '{0, 8'h08, 1'b0, 2'b00, 32'hDEADBEEF, 32'hE3A00005, 2,
                8'h08, 1'b1, 2'b10, 32'h0, 32'hE3A00005, 0, 3};
    vecs[1] = '{1, 8'h2C, 1'b0, 2'b00, 32'h000000AB, 32'h99999999, 1,
                8'h2C, 1'b0, 2'b00, 32'h000000AB, 32'hE3A00005, 0, 2};
    vecs[2] = '{1, 8'h40, 1'b1, 2'b01, 32'h00000055, 32'hCAFEF00D, 3,
                8'h40, 1'b1, 2'b01, 32'h00000055, 32'hCAFEF00D, 0, 4};
    vecs[3] = '{1, 8'h44, 1'b0, 2'b10, 32'h12345678, 32'h0BADF00D, -1,
                8'h44, 1'b0, 2'b10, 32'h12345678, 32'hCAFEF00D, 1, 15};
    vecs[4] = '{0, 8'h0C, 1'b1, 2'b01, 32'h00000077, 32'h0BADF00D, -1,
                8'h0C, 1'b1, 2'b10, 32'h0, 32'hCAFEF00D, 1, 15};
    vecs[5] = '{1, 8'h48, 1'b1, 2'b10, 32'h0, 32'h13579BDF, 14,
                8'h48, 1'b1, 2'b10, 32'h0, 32'h13579BDF, 0, 15};
    vecs[6] = '{0, 8'hFC, 1'b0, 2'b11, 32'hFFFFFFFF, 32'h11223344, 1,
                8'hFC, 1'b1, 2'b10, 32'h0, 32'h11223344, 0, 2};
    vecs[7] = '{1, 8'h50, 1'b1, 2'b00, 32'h0, 32'h0F0F0F0F, -1,
                8'h50, 1'b1, 2'b00, 32'h0, 32'h11223344, 1, 15};

    // Reset state, checked before any clock edge.
    reset = 1'b1;
    #3;
    check("rst_mfa", 32'(bus.mem_mfa), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pulses", 32'({bus.f_done, bus.d_done, bus.f_err, bus.d_err}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_rw", 32'(bus.mem_rw), 32'd1);
    check("rst_mem_type", 32'(bus.mem_type), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Tie: both held high from a fresh reset; expect F, D, F, D with one IDLE cycle between.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.f_addr  = 8'h10;
    bus.d_addr  = 8'h20;
    bus.d_rw    = 1'b1;
    bus.d_type  = 2'b10;
    bus.d_wdata = 32'h0;
    bus.mem_dout = 32'hA5A5A5A5;
    bus.f_req   = 1'b1;
    bus.d_req   = 1'b1;
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int g = 0; g < 4; g++) begin
      wait_mfa(seen, idle);
      check($sformatf("tie%0d_mfa_seen", g), 32'(seen), 32'd1);
      if (g > 0) check($sformatf("tie%0d_idle_gap", g), 32'(idle), 32'd1);
      want_data = order.pop_front();
      check($sformatf("tie%0d_mem_addr", g), 32'(bus.mem_addr), want_data ? 32'h20 : 32'h10);
      @(negedge clk);
      bus.mem_mfc = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (bus.f_done || bus.d_done) got = 1'b1;
      end
      bus.mem_mfc = 1'b0;
      check($sformatf("tie%0d_done_seen", g), 32'(got), 32'd1);
      check($sformatf("tie%0d_f_done", g), 32'(bus.f_done), 32'(!want_data));
      check($sformatf("tie%0d_d_done", g), 32'(bus.d_done), 32'(want_data));
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-ACCESS: everything drops without waiting for a clock edge.
    bus.f_addr = 8'h33;
    bus.f_req  = 1'b1;
    wait_mfa(seen, idle);
    check("rma_mfa_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rma_mfa", 32'(bus.mem_mfa), 32'd0);
    check("rma_busy", 32'(bus.busy), 32'd0);
    check("rma_pulses", 32'({bus.f_done, bus.d_done, bus.f_err, bus.d_err}), 32'd0);
    check("rma_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rma_rdata", bus.rdata, 32'd0);
    bus.f_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rma_quiet%0d", i),
            32'({bus.busy, bus.f_done, bus.d_done, bus.f_err, bus.d_err}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
